seq_bin_to_bcd_cnvrt: RTL and testbench

- Multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble), with a start/done handshake.
- Sits between the 8-bit integer square root finder controller (upstream) and the 4-digit seven-segment display (downstream).
- Converts one WIDTH-bit unsigned value into three registered BCD digits (hundreds, tens, ones).
- Used in place of a combinational converter, so any WIDTH up to 9 meets timing with a single 3-digit datapath.

---
 rtl/seq_bin_to_bcd_cnvrt_if.sv | 15 +
 rtl/seq_bin_to_bcd_cnvrt.sv | 103 ++++++++++
 tb/tb_seq_bin_to_bcd_cnvrt.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_bin_to_bcd_cnvrt_if.sv
// Handshake and digit bus between the converter and its controller/display.
interface seq_bin_to_bcd_cnvrt_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] bin;
  logic             busy;
  logic             done;
  logic [3:0]       hundreds;
  logic [3:0]       tens;
  logic [3:0]       ones;

  modport master (output start, bin, input busy, done, hundreds, tens, ones);
  modport slave  (input start, bin, output busy, done, hundreds, tens, ones);
endinterface

// File: rtl/seq_bin_to_bcd_cnvrt.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional macro SEQ_BIN_TO_BCD_LEADING_ZERO_BLANK_EN blanks leading zero digits to 4'hF.
module seq_bin_to_bcd_cnvrt #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  seq_bin_to_bcd_cnvrt_if.slave    bus
);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;
  localparam logic [3:0] CNT_LAST = 4'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [11:0]      scr_q, scr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [3:0]       hun_q, hun_d;
  logic [3:0]       ten_q, ten_d;
  logic [3:0]       one_q, one_d;
  logic [11:0]      adj;
  logic [11:0]      scr_shift;

  always_comb begin
    // add-3 on every digit >= 5 before the shift, all digits in parallel
    adj = scr_q;
    for (int i = 0; i < 3; i++)
      if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    scr_shift = (adj << 1) | {11'b0, sh_q[WIDTH-1]};

    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    scr_d   = scr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hun_d   = hun_q;
    ten_d   = ten_q;
    one_d   = one_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sh_d    = bus.bin;
          scr_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      default: begin
        scr_d = scr_shift;
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          hun_d   = scr_shift[11:8];
          ten_d   = scr_shift[7:4];
          one_d   = scr_shift[3:0];
`ifdef SEQ_BIN_TO_BCD_LEADING_ZERO_BLANK_EN
          if (scr_shift[11:8] == 4'd0) hun_d = 4'hF;
          if (scr_shift[11:4] == 8'd0) ten_d = 4'hF;
`else
`endif
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      scr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hun_q   <= '0;
      ten_q   <= '0;
      one_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      scr_q   <= scr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hun_q   <= hun_d;
      ten_q   <= ten_d;
      one_q   <= one_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.hundreds = hun_q;
  assign bus.tens     = ten_q;
  assign bus.ones     = one_q;
endmodule

// File: tb/tb_seq_bin_to_bcd_cnvrt.sv
// Scoreboard bench for seq_bin_to_bcd_cnvrt (WIDTH=8); honours SEQ_BIN_TO_BCD_LEADING_ZERO_BLANK_EN.
module tb_seq_bin_to_bcd_cnvrt;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  seq_bin_to_bcd_cnvrt_if #(.WIDTH(WIDTH)) bus ();
  seq_bin_to_bcd_cnvrt #(.WIDTH(WIDTH)) dut (.clk(clk), .clr(clr), .bus(bus));

  int total = 0;
  int bad   = 0;
  logic [11:0] exp_q[$];

  function automatic logic [11:0] ref_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
`ifdef SEQ_BIN_TO_BCD_LEADING_ZERO_BLANK_EN
    if (v < 10) t = 4'hF;
    if (v < 100) h = 4'hF;
`endif
    return {h, t, o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive start for one edge (E0) and record the expected result
  task automatic start_conv(input int v);
    bus.start = 1'b1;
    bus.bin   = 8'(v);
    exp_q.push_back(ref_bcd(v));
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit got);
    cyc = 0;
    got = 1'b0;
    while (cyc < 40 && !got) begin
      tick();
      cyc++;
      if (bus.done === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.bin   = '0;
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    total++;
    if ({bus.busy, bus.done, bus.hundreds, bus.tens, bus.ones} !== 14'd0) begin
      bad++;
      $display("FAIL reset: busy/done/digits got %b %b %h%h%h want 0 0 000",
               bus.busy, bus.done, bus.hundreds, bus.tens, bus.ones);
    end
  endtask

  task automatic test_max_timing();
    logic [11:0] e;
    start_conv(255);
    for (int k = 1; k < WIDTH; k++) begin
      total++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        bad++;
        $display("FAIL busy_window: cycle %0d busy=%b done=%b want busy=1 done=0", k, bus.busy, bus.done);
      end
      tick();
    end
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_last: busy=%b want 1", bus.busy);
    end
    tick();
    e = exp_q.pop_front();
    total++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || {bus.hundreds, bus.tens, bus.ones} !== e) begin
      bad++;
      $display("FAIL done_255: done=%b busy=%b digits=%h want done=1 busy=0 digits=%h",
               bus.done, bus.busy, {bus.hundreds, bus.tens, bus.ones}, e);
    end
    tick();
    total++;
    if (bus.done !== 1'b0 || {bus.hundreds, bus.tens, bus.ones} !== e) begin
      bad++;
      $display("FAIL done_width: done=%b digits=%h want done=0 digits=%h",
               bus.done, {bus.hundreds, bus.tens, bus.ones}, e);
    end
  endtask

  task automatic test_values();
    int vals[8] = '{0, 9, 100, 199, 7, 40, 105, 255};
    int cyc;
    bit got;
    logic [11:0] e;
    for (int n = 0; n < 8 + 256; n++) begin
      start_conv(n < 8 ? vals[n] : n - 8);
      wait_done(cyc, got);
      e = exp_q.pop_front();
      total++;
      if (!got || cyc != WIDTH || {bus.hundreds, bus.tens, bus.ones} !== e) begin
        bad++;
        $display("FAIL convert: input %0d got=%b cycles=%0d digits=%h want cycles=%0d digits=%h",
                 n < 8 ? vals[n] : n - 8, got, cyc, {bus.hundreds, bus.tens, bus.ones}, WIDTH, e);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int cyc, extra;
    bit got;
    logic [11:0] e;
    start_conv(144);
    tick();
    tick();
    bus.start = 1'b1;
    bus.bin   = 8'd81;
    tick();
    bus.start = 1'b0;
    wait_done(cyc, got);
    e = exp_q.pop_front();
    total++;
    if (!got || cyc != WIDTH - 3 || {bus.hundreds, bus.tens, bus.ones} !== e) begin
      bad++;
      $display("FAIL busy_ignore: got=%b cycles=%0d digits=%h want cycles=%0d digits=%h",
               got, cyc, {bus.hundreds, bus.tens, bus.ones}, WIDTH - 3, e);
    end
    extra = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (bus.done === 1'b1) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL busy_ignore_extra: extra done pulses %0d want 0", extra);
    end
  endtask

  task automatic test_clr_abort();
    int cyc, dones;
    bit got;
    logic [11:0] e;
    start_conv(200);
    wait_done(cyc, got);
    e = exp_q.pop_front();
    total++;
    if (!got || {bus.hundreds, bus.tens, bus.ones} !== e) begin
      bad++;
      $display("FAIL pre_abort: got=%b digits=%h want %h", got, {bus.hundreds, bus.tens, bus.ones}, e);
    end
    bus.start = 1'b1;
    bus.bin   = 8'd37;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total++;
    if ({bus.busy, bus.done, bus.hundreds, bus.tens, bus.ones} !== 14'd0) begin
      bad++;
      $display("FAIL abort_state: busy=%b done=%b digits=%h want 0 0 000",
               bus.busy, bus.done, {bus.hundreds, bus.tens, bus.ones});
    end
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    total++;
    if (dones != 0 || {bus.hundreds, bus.tens, bus.ones} !== 12'd0) begin
      bad++;
      $display("FAIL abort_no_done: pulses=%0d digits=%h want 0 000", dones, {bus.hundreds, bus.tens, bus.ones});
    end
    start_conv(37);
    wait_done(cyc, got);
    e = exp_q.pop_front();
    total++;
    if (!got || cyc != WIDTH || {bus.hundreds, bus.tens, bus.ones} !== e) begin
      bad++;
      $display("FAIL post_abort: got=%b cycles=%0d digits=%h want cycles=%0d digits=%h",
               got, cyc, {bus.hundreds, bus.tens, bus.ones}, WIDTH, e);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit got;
    logic [11:0] e;
    bus.start = 1'b1;
    bus.bin   = 8'd64;
    exp_q.push_back(ref_bcd(64));
    tick();
    wait_done(cyc, got);
    e = exp_q.pop_front();
    total++;
    if (!got || cyc != WIDTH || {bus.hundreds, bus.tens, bus.ones} !== e) begin
      bad++;
      $display("FAIL b2b_first: got=%b cycles=%0d digits=%h want cycles=%0d digits=%h",
               got, cyc, {bus.hundreds, bus.tens, bus.ones}, WIDTH, e);
    end
    for (int n = 0; n < 4; n++) begin
      exp_q.push_back(ref_bcd(64));
      cyc = 0;
      got = 1'b0;
      while (cyc < 40 && !got) begin
        tick();
        cyc++;
        if (bus.done === 1'b1) got = 1'b1;
        else if ({bus.hundreds, bus.tens, bus.ones} !== e) begin
          bad++;
          total++;
          $display("FAIL b2b_hold: digits=%h want %h", {bus.hundreds, bus.tens, bus.ones}, e);
        end
      end
      if (n == 3) bus.start = 1'b0;
      e = exp_q.pop_front();
      total++;
      if (!got || cyc != WIDTH + 1 || {bus.hundreds, bus.tens, bus.ones} !== e) begin
        bad++;
        $display("FAIL b2b_period: got=%b period=%0d digits=%h want period=%0d digits=%h",
                 got, cyc, {bus.hundreds, bus.tens, bus.ones}, WIDTH + 1, e);
      end
    end
    tick();
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_release: busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
  endtask

  initial begin
    test_reset();
    test_max_timing();
    test_values();
    test_start_while_busy();
    test_clr_abort();
    test_back_to_back();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d results left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
